jk_register_bank: RTL and testbench

Parametrised bank of WIDTH independent JK flip-flops sharing one clock and one reset. Each bit runs in a run-time selectable mode: JK, D or T. The bank also supports synchronous parallel load and global enable. It reports per-bit change strobes aligned with Q, and serves as the generalised successor to the single-bit JK flip-flop for register/flag storage in the design.

---
 rtl/jk_register_bank.sv | 102 ++++++++++
 tb/tb_jk_register_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// Bank of WIDTH independent JK/D/T flip-flops with parallel load, change strobes
// and an optional saturating toggle counter (enabled by defining JK_TOGGLE_CNT_EN).
module jk_register_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] changed,
`ifdef JK_TOGGLE_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt,
`endif
  output logic             any_changed
);

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q;
  logic             any_changed_q;
  logic [WIDTH-1:0] diff;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (en) begin
      case (mode)
        MODE_JK: q_d = (J & ~q_q) | (~K & q_q);
        MODE_D:  q_d = J;
        MODE_T:  q_d = q_q ^ J;
        default: q_d = q_q;
      endcase
    end
  end

  assign diff = q_d ^ q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q           <= RST_VAL;
      changed_q     <= '0;
      any_changed_q <= 1'b0;
    end else begin
      q_q           <= q_d;
      changed_q     <= diff;
      any_changed_q <= |diff;
    end
  end

  assign Q           = q_q;
  assign Qn          = ~q_q;
  assign changed     = changed_q;
  assign any_changed = any_changed_q;

`ifdef JK_TOGGLE_CNT_EN
  // Popcount of up to 64 bits fits in 7 bits, so the sum never overflows SUM_W.
  localparam int SUM_W = CNT_W + 7;

  function automatic logic [6:0] popcount(input logic [WIDTH-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + 7'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [6:0]       b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = sat_add(cnt_q, popcount(diff));
    if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign toggle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed self-checking bench for jk_register_bank (WIDTH=8, CNT_W=4).
module tb_jk_register_bank;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk, reset, en, load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_data, J, K, Q, Qn, changed;
  logic             any_changed;
`ifdef JK_TOGGLE_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] toggle_cnt;
`endif

  int checks = 0;
  int failures = 0;

  jk_register_bank #(.WIDTH(WIDTH), .RST_VAL(8'h00), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_data(load_data), .J(J), .K(K), .Q(Q), .Qn(Qn), .changed(changed),
`ifdef JK_TOGGLE_CNT_EN
    .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt),
`endif
    .any_changed(any_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00;
    load_data = '0; J = '0; K = '0;
`ifdef JK_TOGGLE_CNT_EN
    cnt_clr = 1'b0;
`endif
    #12;
    chk("rst_q", 64'(Q), 64'h00);
    chk("rst_qn", 64'(Qn), 64'hFF);
    chk("rst_chg", 64'(changed), 64'h00);
    chk("rst_any", 64'(any_changed), 64'h0);
    reset = 1'b0;

    // Preload A5, then reset asynchronously between edges
    load = 1'b1; load_data = 8'hA5;
    step();
    chk("load_a5", 64'(Q), 64'hA5);
    chk("load_a5_chg", 64'(changed), 64'hA5);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_q", 64'(Q), 64'h00);
    chk("async_qn", 64'(Qn), 64'hFF);
    chk("async_chg", 64'(changed), 64'h00);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_en0", 64'(Q), 64'h00);
    end

    // JK mode
    en = 1'b1; mode = 2'b00; J = 8'hF0; K = 8'h0F;
    step();
    chk("jk_set", 64'(Q), 64'hF0);
    chk("jk_set_chg", 64'(changed), 64'hF0);
    J = 8'hFF; K = 8'hFF;
    step();
    chk("jk_tgl", 64'(Q), 64'h0F);
    chk("jk_tgl_chg", 64'(changed), 64'hFF);
    chk("jk_tgl_any", 64'(any_changed), 64'h1);
    J = 8'h00; K = 8'h00;
    step();
    chk("jk_hold", 64'(Q), 64'h0F);
    chk("jk_hold_chg", 64'(changed), 64'h00);
    chk("jk_hold_any", 64'(any_changed), 64'h0);

    // D, T and hold modes
    mode = 2'b01; J = 8'h3C;
    step();
    chk("d_mode", 64'(Q), 64'h3C);
    chk("d_mode_chg", 64'(changed), 64'h33);
    mode = 2'b10; J = 8'h01;
    step();
    chk("t_mode", 64'(Q), 64'h3D);
    chk("t_mode_chg", 64'(changed), 64'h01);
    mode = 2'b11; J = 8'hFF; K = 8'hFF;
    step();
    chk("m11_hold", 64'(Q), 64'h3D);
    chk("m11_chg", 64'(changed), 64'h00);
    chk("m11_any", 64'(any_changed), 64'h0);

    // Load priority over JK toggle
    load = 1'b1; load_data = 8'h3D; mode = 2'b00;
    step();
    chk("ld_same", 64'(Q), 64'h3D);
    chk("ld_same_chg", 64'(changed), 64'h00);
    load_data = 8'hC3; en = 1'b0;
    step();
    chk("ld_c3", 64'(Q), 64'hC3);
    chk("ld_c3_chg", 64'(changed), 64'hFE);
    chk("ld_c3_any", 64'(any_changed), 64'h1);

    // Toggle counter: clear alongside load of 00, then two full toggles
    load_data = 8'h00;
`ifdef JK_TOGGLE_CNT_EN
    cnt_clr = 1'b1;
`endif
    step();
    chk("ld_00", 64'(Q), 64'h00);
`ifdef JK_TOGGLE_CNT_EN
    chk("cnt_clr_ld", 64'(toggle_cnt), 64'd0);
    cnt_clr = 1'b0;
`endif
    load = 1'b0; en = 1'b1; mode = 2'b00; J = 8'hFF; K = 8'hFF;
    step();
    chk("tgl1", 64'(Q), 64'hFF);
`ifdef JK_TOGGLE_CNT_EN
    chk("cnt_8", 64'(toggle_cnt), 64'd8);
`endif
    step();
    chk("tgl2", 64'(Q), 64'h00);
`ifdef JK_TOGGLE_CNT_EN
    chk("cnt_sat", 64'(toggle_cnt), 64'd15);
    cnt_clr = 1'b1;
`endif
    mode = 2'b10; J = 8'h01;
    step();
    chk("t_one", 64'(Q), 64'h01);
`ifdef JK_TOGGLE_CNT_EN
    chk("cnt_clr_pri", 64'(toggle_cnt), 64'd0);
    cnt_clr = 1'b0;
`endif

    // Reset during T-mode activity
    J = 8'hFF;
    step();
    chk("act_fe", 64'(Q), 64'hFE);
    step();
    chk("act_01", 64'(Q), 64'h01);
    #2 reset = 1'b1;
    #1;
    chk("act_rst_q", 64'(Q), 64'h00);
    chk("act_rst_chg", 64'(changed), 64'h00);
    chk("act_rst_any", 64'(any_changed), 64'h0);
`ifdef JK_TOGGLE_CNT_EN
    chk("act_rst_cnt", 64'(toggle_cnt), 64'd0);
`endif
    #1 reset = 1'b0;
    step();
    chk("post_rst_q", 64'(Q), 64'hFF);
    chk("post_rst_qn", 64'(Qn), 64'h00);
    chk("post_rst_chg", 64'(changed), 64'hFF);
`ifdef JK_TOGGLE_CNT_EN
    chk("post_rst_cnt", 64'(toggle_cnt), 64'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
